// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FP issue controller.
//   state_t        : controller FSM encoding (IDLE / EXEC / WB)
//   OP_*           : alu_op codes coming from the control unit
//   DEF_LAT_*      : default FPU latencies in cycles
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_FMA = 3'b100;

    localparam int DEF_LAT_ADD = 3;
    localparam int DEF_LAT_MUL = 4;
    localparam int DEF_LAT_FMA = 6;

endpackage

// File: rtl/fpu_lat_decode.sv
// Maps an alu_op to the FPU latency in cycles.
//   op  : alu_op (3 bits)
//   lat : latency 1..15; 0 for NOP (never used, NOPs are not issued)
// Add/sub use LAT_ADD, mul uses LAT_MUL, FMA and every other nonzero
// code use LAT_FMA.
module fpu_lat_decode
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_ADD = DEF_LAT_ADD,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_FMA = DEF_LAT_FMA
) (
    input  logic [2:0] op,
    output logic [3:0] lat
);

    always_comb begin
        lat = 4'(LAT_FMA);
        case (op)
            OP_NOP:         lat = 4'd0;
            OP_ADD, OP_SUB: lat = 4'(LAT_ADD);
            OP_MUL:         lat = 4'(LAT_MUL);
            default:        lat = 4'(LAT_FMA);
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue controller sequencing one FP operation at a time through a
// fixed-latency FPU and writing the result back to the register file.
//   clk, reset                 : clock, synchronous active-high reset
//   issue_valid/ready/op/wreg  : instruction handshake from decode
//   issue_rs1/rs2/rs3          : source registers, checked against wb_reg
//   fpu_start, fpu_op          : start pulse and opcode to the FPU
//   fpu_result                 : FPU result bus
//   wb_en, wb_reg, wb_data     : register-file write port
//   stall_pc                   : hold the PC (valid but not ready)
//   busy                       : an operation is in flight
//   state_dbg                  : current FSM state, for observation
//
// Handshake: an instruction transfers on a rising clk edge where
// issue_valid && issue_ready. issue_ready does not depend on issue_op, but
// in WB it drops when issue_valid is high and a source register matches
// wb_reg, so a dependent instruction waits for the write-back to land.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT_ADD = DEF_LAT_ADD,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_FMA = DEF_LAT_FMA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_op,
    input  logic [4:0]  issue_wreg,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rs3,
    output logic        fpu_start,
    output logic [2:0]  fpu_op,
    input  logic [31:0] fpu_result,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        stall_pc,
    output logic        busy,
    output state_t      state_dbg
);

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [4:0]  wreg_q;
    logic [3:0]  cnt_q;
    logic        first_q;   // high during the first EXEC cycle only
    logic [3:0]  lat;
    logic        hazard;
    logic        load;      // accept a nonzero op this cycle
    logic        sample;    // last EXEC cycle: capture the FPU result

    fpu_lat_decode #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_FMA (LAT_FMA)
    ) u_lat (
        .op  (issue_op),
        .lat (lat)
    );

    assign hazard = issue_valid &&
                    ((issue_rs1 == wb_reg) || (issue_rs2 == wb_reg) ||
                     (issue_rs3 == wb_reg));
    assign sample = (state_q == ST_EXEC) && (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        issue_ready = 1'b0;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid && issue_op != OP_NOP) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) state_d = ST_WB;
            end
            ST_WB: begin
                issue_ready = !hazard;
                if (issue_valid && !hazard && issue_op != OP_NOP) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            wreg_q  <= 5'd0;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
            wb_reg  <= 5'd0;
            wb_data <= 32'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q    <= issue_op;
                wreg_q  <= issue_wreg;
                cnt_q   <= lat - 4'd1;
                first_q <= 1'b1;
            end else if (state_q == ST_EXEC) begin
                first_q <= 1'b0;
                if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            end
            if (sample) begin
                wb_reg  <= wreg_q;
                wb_data <= fpu_result;
            end
        end
    end

    assign fpu_start = (state_q == ST_EXEC) && first_q;
    assign fpu_op    = (state_q == ST_EXEC) ? op_q : 3'd0;
    assign wb_en     = (state_q == ST_WB);
    assign stall_pc  = issue_valid && !issue_ready;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: default-latency instance plus a LAT_ADD=1 build.
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default DUT ----------------
    logic        issue_valid = 1'b0, issue_ready;
    logic [2:0]  issue_op = 3'd0;
    logic [4:0]  issue_wreg = 5'd0, issue_rs1 = 5'd0, issue_rs2 = 5'd0, issue_rs3 = 5'd0;
    logic        fpu_start, wb_en, stall_pc, busy;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_result, wb_data;
    logic [4:0]  wb_reg;
    state_t      state_dbg;
    logic [31:0] res_base = 32'd0;
    logic        res_ramp = 1'b0;

    assign fpu_result = res_base + (res_ramp ? 32'(cyc) : 32'd0);

    fpu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_wreg(issue_wreg),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rs3(issue_rs3),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_result(fpu_result),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .stall_pc(stall_pc), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- LAT_ADD=1 DUT ----------------
    logic        v1 = 1'b0, ready1;
    logic [2:0]  op1 = 3'd0;
    logic [4:0]  wreg1 = 5'd0;
    logic        start1, wb_en1, stall1, busy1;
    logic [2:0]  fpu_op1;
    logic [31:0] res1, wb_data1;
    logic [4:0]  wb_reg1;
    state_t      state1;
    localparam logic [31:0] BASE1 = 32'h3F80_0000;

    assign res1 = BASE1 + 32'(cyc);

    fpu_issue_ctrl #(.LAT_ADD(1)) dut1 (
        .clk(clk), .reset(reset),
        .issue_valid(v1), .issue_ready(ready1),
        .issue_op(op1), .issue_wreg(wreg1),
        .issue_rs1(5'd0), .issue_rs2(5'd0), .issue_rs3(5'd0),
        .fpu_start(start1), .fpu_op(fpu_op1), .fpu_result(res1),
        .wb_en(wb_en1), .wb_reg(wb_reg1), .wb_data(wb_data1),
        .stall_pc(stall1), .busy(busy1), .state_dbg(state1)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [52:0] exp_q[$];   // {wb cycle[15:0], wreg[4:0], data[31:0]}
    logic [18:0] st_q[$];    // {start cycle[15:0], op[2:0]}
    logic        mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return 3;
            3'd3:       return 4;
            default:    return 6;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0][52:37] == 16'(cyc)) begin
                logic [52:0] e;
                e = exp_q.pop_front();
                chk("wb_en", 32'(wb_en), 32'd1);
                chk("wb_reg", 32'(wb_reg), 32'(e[36:32]));
                chk("wb_data", wb_data, e[31:0]);
            end else begin
                chk("wb_en_quiet", 32'(wb_en), 32'd0);
            end
            if (st_q.size() > 0 && st_q[0][18:3] == 16'(cyc)) begin
                logic [18:0] s;
                s = st_q.pop_front();
                chk("fpu_start", 32'(fpu_start), 32'd1);
                chk("fpu_op", 32'(fpu_op), 32'(s[2:0]));
            end else begin
                chk("fpu_start_quiet", 32'(fpu_start), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded).
    // Called right after a rising edge; exp_acc is the cycle it should transfer in.
    task automatic send(input logic [2:0] op, input logic [4:0] wreg,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                        input int exp_acc);
        int acc;
        int l;
        acc = -1;
        issue_valid = 1'b1; issue_op = op; issue_wreg = wreg;
        issue_rs1 = r1; issue_rs2 = r2; issue_rs3 = r3;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            chk("stall_pc", 32'(stall_pc), 32'(!issue_ready));
            if (issue_ready) acc = cyc;
        end
        chk("accept_cycle", 32'(acc), 32'(exp_acc));
        if (acc >= 0 && op != 3'd0) begin
            l = lat_of(op);
            st_q.push_back({16'(acc + 1), op});
            exp_q.push_back({16'(acc + l + 1), wreg,
                             res_base + (res_ramp ? 32'(acc + l) : 32'd0)});
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0; issue_op = 3'd0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a;
        // Reset with a valid op presented: reset must win.
        issue_valid = 1'b1; issue_op = 3'd1; issue_wreg = 5'd9;
        v1 = 1'b1; op1 = 3'd1;
        step(3);
        reset = 1'b0;
        issue_valid = 1'b0; issue_op = 3'd0; v1 = 1'b0; op1 = 3'd0;
        @(negedge clk);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_start", 32'(fpu_start), 32'd0);
        chk("rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single add, constant FPU result.
        res_base = 32'h4040_0000; res_ramp = 1'b0;
        send(3'd1, 5'd5, 5'd1, 5'd2, 5'd3, cyc);
        step(6);

        // FMA then mul held valid: mul accepted in the FMA's WB cycle.
        res_base = 32'h1000_0000; res_ramp = 1'b1;
        a = cyc;
        send(3'd4, 5'd9, 5'd1, 5'd2, 5'd3, a);
        send(3'd3, 5'd10, 5'd1, 5'd2, 5'd3, a + 7);
        step(8);

        // RAW hazard in WB via each source slot, then a non-dependent op.
        for (int k = 0; k < 4; k++) begin
            logic [4:0] w;
            w = 5'(20 + k);
            a = cyc;
            send(3'd1, w, 5'd0, 5'd0, 5'd0, a);
            step(3);   // now in the WB cycle a+4
            send(3'd2, 5'd25, (k == 0) ? w : 5'd1, (k == 1) ? w : 5'd2,
                 (k == 2) ? w : 5'd3, (k == 3) ? a + 4 : a + 5);
            step(6);
        end

        // Write-back to register 0.
        a = cyc;
        send(3'd4, 5'd0, 5'd4, 5'd4, 5'd4, a);
        step(8);

        // Random ops from idle.
        for (int k = 0; k < 6; k++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 7));
            res_base = $urandom;
            send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), cyc);
            step(lat_of(op) + 2);
        end

        // Reset in the second EXEC cycle of a mul: no write-back.
        a = cyc;
        send(3'd3, 5'd14, 5'd1, 5'd2, 5'd3, a);
        step(1);          // cycle a+2
        reset = 1'b1;
        step(1);          // cycle a+3
        reset = 1'b0;
        exp_q.delete();
        st_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("mid_rst_fpu_op", 32'(fpu_op), 32'd0);
        chk("mid_rst_ready", 32'(issue_ready), 32'd1);
        @(posedge clk); #1;
        step(8);

        // NOP stream: nothing happens.
        issue_valid = 1'b1; issue_op = 3'd0; issue_wreg = 5'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nop_busy", 32'(busy), 32'd0);
            chk("nop_ready", 32'(issue_ready), 32'd1);
            chk("nop_stall", 32'(stall_pc), 32'd0);
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
        step(3);

        // LAT_ADD=1 build: start in cycle 1, write-back in cycle 2.
        a = cyc;
        v1 = 1'b1; op1 = 3'd1; wreg1 = 5'd3;
        @(negedge clk);
        chk("l1_ready", 32'(ready1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0; op1 = 3'd0;
        @(negedge clk);
        chk("l1_start", 32'(start1), 32'd1);
        chk("l1_wb_early", 32'(wb_en1), 32'd0);
        @(negedge clk);
        chk("l1_wb_en", 32'(wb_en1), 32'd1);
        chk("l1_wb_reg", 32'(wb_reg1), 32'd3);
        chk("l1_wb_data", wb_data1, BASE1 + 32'(a + 1));
        chk("l1_start_off", 32'(start1), 32'd0);
        @(negedge clk);
        chk("l1_wb_once", 32'(wb_en1), 32'd0);
        chk("l1_busy", 32'(busy1), 32'd0);

        step(2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("st_q_drained", 32'(st_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
